// File: rtl/csr_sram1_writer_pkg.sv
// Shared definitions for the CSR SRAM1 writer and reader.
// Holds the SRAM1 word geometry, the row_ptr/col_idx packing constants
// and the writer state encoding.
package csr_sram1_writer_pkg;

  localparam int DATA_W = 256;  // SRAM1 word width
  localparam int ADDR_W = 5;    // SRAM1 address width
  localparam int RP_W   = 8;    // row_ptr entry width
  localparam int RP_N   = 17;   // row_ptr entries per word
  localparam int CI_W   = 4;    // col_idx entry width
  localparam int CI_N   = 64;   // col_idx entries per word
  localparam int CNT_W  = 8;    // col_idx session counter width

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RP_FILL  = 3'd1,
    RP_WRITE = 3'd2,
    CI_FILL  = 3'd3,
    CI_WRITE = 3'd4,
    DONE     = 3'd5
  } state_t;

endpackage

// File: rtl/csr_sram1_writer_if.sv
// Bundle of the writer's control, stream and SRAM1 write signals.
// Handshake rule for both streams: a transfer happens on a rising edge
// where valid && ready; valid must not depend on ready, data is only
// meaningful while valid is high, and ready is a pure function of state.
interface csr_sram1_writer_if;
  import csr_sram1_writer_pkg::*;

  logic              i_start;
  logic [ADDR_W-1:0] i_base_addr;
  logic              i_rp_valid;
  logic [RP_W-1:0]   i_rp_data;
  logic              o_rp_ready;
  logic              i_ci_valid;
  logic [CI_W-1:0]   i_ci_data;
  logic              i_ci_last;
  logic              o_ci_ready;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [DATA_W-1:0] o_wr_data;
  logic [CNT_W-1:0]  o_ci_count;
  logic              o_busy;
  logic              o_done;
  logic [2:0]        o_state;

  // The writer itself
  modport slave (
    input  i_start, i_base_addr, i_rp_valid, i_rp_data,
           i_ci_valid, i_ci_data, i_ci_last,
    output o_rp_ready, o_ci_ready, o_wr_en, o_wr_addr, o_wr_data,
           o_ci_count, o_busy, o_done, o_state
  );

  // Whoever feeds the streams and watches the SRAM1 port
  modport master (
    output i_start, i_base_addr, i_rp_valid, i_rp_data,
           i_ci_valid, i_ci_data, i_ci_last,
    input  o_rp_ready, o_ci_ready, o_wr_en, o_wr_addr, o_wr_data,
           o_ci_count, o_busy, o_done, o_state
  );

endinterface

// File: rtl/csr_sram1_writer_nibble_packer.sv
// csr_nibble_packer: word-wide register written one lane at a time.
// A write stores one LANE_W lane, or two adjacent lanes when 'wide' is set
// (used for the double-width row_ptr entries). 'clr' zeroes the word and
// wins over a write. 'nxt' exposes the value the register takes at the
// next edge so the owner can launch a word that includes the final entry.
module csr_nibble_packer #(
  parameter int DATA_W     = 256,
  parameter int LANE_W     = 4,
  parameter int LANE_IDX_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr,
  input  logic                  wide,
  input  logic [LANE_IDX_W-1:0] lane,
  input  logic [2*LANE_W-1:0]   data,
  output logic [DATA_W-1:0]     nxt
);

  logic [DATA_W-1:0] buf_q;
  logic [DATA_W-1:0] buf_d;

  // Next word: clear, or merge the addressed lane(s) into the held word
  always_comb begin
    buf_d = buf_q;
    if (clr) begin
      buf_d = '0;
    end else if (wr) begin
      buf_d[int'(lane)*LANE_W +: LANE_W] = data[LANE_W-1:0];
      if (wide && (lane != '1)) begin
        buf_d[(int'(lane)+1)*LANE_W +: LANE_W] = data[2*LANE_W-1:LANE_W];
      end
    end
  end

  // Word register
  always_ff @(posedge clk) begin
    if (rst) buf_q <= '0;
    else     buf_q <= buf_d;
  end

  assign nxt = buf_d;

endmodule

// File: rtl/csr_sram1_writer.sv
// csr_sram1_writer: packs one row_ptr word (17 x 8 bit) followed by one or
// more col_idx words (64 x 4 bit each) into consecutive SRAM1 addresses
// starting at the latched base address. The SRAM1 write port is fully
// registered; each write is launched on the edge of the completing transfer.
// Optional build macro: CSR_SRAM1_WR_ABORT_EN adds i_abort, which drops
// any session back to IDLE with no further write and no done pulse.
module csr_sram1_writer
  import csr_sram1_writer_pkg::*;
#(
  parameter int DATA_W = csr_sram1_writer_pkg::DATA_W,
  parameter int ADDR_W = csr_sram1_writer_pkg::ADDR_W,
  parameter int RP_W   = csr_sram1_writer_pkg::RP_W,
  parameter int RP_N   = csr_sram1_writer_pkg::RP_N,
  parameter int CI_W   = csr_sram1_writer_pkg::CI_W,
  parameter int CI_N   = csr_sram1_writer_pkg::CI_N
) (
  input logic               i_clk,
  input logic               i_rst,
`ifdef CSR_SRAM1_WR_ABORT_EN
  input logic               i_abort,
`endif
  csr_sram1_writer_if.slave bus
);

  localparam int RP_IDX_W   = $clog2(RP_N);
  localparam int LANE_IDX_W = $clog2(CI_N);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [RP_IDX_W-1:0] rp_idx_q, rp_idx_d;
  logic [CNT_W-1:0]    ci_count_q, ci_count_d;
  logic                last_q, last_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  logic                  rp_fire, ci_fire, ci_is_last;
  logic                  pk_clr, pk_wr, pk_wide;
  logic [LANE_IDX_W-1:0] pk_lane, ci_lane;
  logic [RP_W-1:0]       pk_data;
  logic [DATA_W-1:0]     pk_nxt;

  assign rp_fire    = (state_q == RP_FILL) && bus.i_rp_valid;
  assign ci_fire    = (state_q == CI_FILL) && bus.i_ci_valid;
  assign ci_lane    = ci_count_q[LANE_IDX_W-1:0];
  // The 256th entry of a session closes it even without i_ci_last
  assign ci_is_last = bus.i_ci_last || (ci_count_q == '1);

  // Packer control: row_ptr entry k fills nibble lanes 2k and 2k+1,
  // col_idx entry n fills lane n mod 64; the word clears on session start
  // and in each write state once its contents have been launched.
  assign pk_clr  = ((state_q == IDLE) && bus.i_start) ||
                   (state_q == RP_WRITE) || (state_q == CI_WRITE);
  assign pk_wr   = rp_fire || ci_fire;
  assign pk_wide = rp_fire;
  assign pk_lane = rp_fire ? LANE_IDX_W'({rp_idx_q, 1'b0}) : ci_lane;
  assign pk_data = rp_fire ? bus.i_rp_data
                           : {{(RP_W-CI_W){1'b0}}, bus.i_ci_data};

  csr_nibble_packer #(
    .DATA_W     (DATA_W),
    .LANE_W     (CI_W),
    .LANE_IDX_W (LANE_IDX_W)
  ) u_packer (
    .clk  (i_clk),
    .rst  (i_rst),
    .clr  (pk_clr),
    .wr   (pk_wr),
    .wide (pk_wide),
    .lane (pk_lane),
    .data (pk_data),
    .nxt  (pk_nxt)
  );

  // Next-state, address, counters and registered write-port values
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rp_idx_d   = rp_idx_q;
    ci_count_d = ci_count_q;
    last_d     = last_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          state_d    = RP_FILL;
          addr_d     = bus.i_base_addr;
          rp_idx_d   = '0;
          ci_count_d = '0;
          last_d     = 1'b0;
        end
      end
      RP_FILL: begin
        if (rp_fire) begin
          rp_idx_d = rp_idx_q + 1'b1;
          if (rp_idx_q == RP_IDX_W'(RP_N - 1)) begin
            state_d   = RP_WRITE;
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = pk_nxt;
          end
        end
      end
      RP_WRITE: begin
        addr_d  = addr_q + 1'b1;
        state_d = CI_FILL;
      end
      CI_FILL: begin
        if (ci_fire) begin
          ci_count_d = ci_count_q + 1'b1;
          if (ci_is_last || (ci_lane == LANE_IDX_W'(CI_N - 1))) begin
            state_d   = CI_WRITE;
            last_d    = ci_is_last;
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = pk_nxt;
          end
        end
      end
      CI_WRITE: begin
        addr_d  = addr_q + 1'b1;
        state_d = last_q ? DONE : CI_FILL;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef CSR_SRAM1_WR_ABORT_EN
    if (i_abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
    end
`endif
  end

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rp_idx_q   <= '0;
      ci_count_q <= '0;
      last_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rp_idx_q   <= rp_idx_d;
      ci_count_q <= ci_count_d;
      last_q     <= last_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign bus.o_rp_ready = (state_q == RP_FILL);
  assign bus.o_ci_ready = (state_q == CI_FILL);
  assign bus.o_wr_en    = wr_en_q;
  assign bus.o_wr_addr  = wr_addr_q;
  assign bus.o_wr_data  = wr_data_q;
  assign bus.o_ci_count = ci_count_q;
  assign bus.o_busy     = (state_q != IDLE);
  assign bus.o_done     = (state_q == DONE);
  assign bus.o_state    = state_q;

endmodule

// File: tb/tb_csr_sram1_writer.sv
// Bench for csr_sram1_writer: a table of sessions plus a mid-session reset
// sequence. Expected SRAM1 writes are built from the driven entries and
// queued; the write monitor pops and compares each one.
module tb_csr_sram1_writer;
  import csr_sram1_writer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csr_sram1_writer_if bus();
`ifdef CSR_SRAM1_WR_ABORT_EN
  logic abort = 1'b0;
`endif

  csr_sram1_writer dut (
    .i_clk   (clk),
    .i_rst   (rst),
`ifdef CSR_SRAM1_WR_ABORT_EN
    .i_abort (abort),
`endif
    .bus     (bus)
  );

  typedef struct {
    logic [ADDR_W-1:0] base;
    int                n_ci;
    bit                rp_mode;    // 0: entry k = k, 1: scrambled
    bit                ci_mode;    // 0: entry n = n%16, 1: scrambled
    bit                gaps;
    bit                start_mid;
    bit                use_last;
    int                exp_writes;
    logic [CNT_W-1:0]  exp_count;
  } sess_t;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [RP_W-1:0] rp_vals[RP_N];
  logic [CI_W-1:0] ci_vals[256];
  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  bit prev_wr_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor / scoreboard
  always @(negedge clk) begin
    logic [ADDR_W+DATA_W-1:0] e;
    if (rst) begin
      prev_wr_en = 1'b0;
    end else begin
      if (bus.o_wr_en) begin
        wr_count++;
        n_checks++;
        if (prev_wr_en) begin
          n_fail++;
          $display("FAIL wr_en_back_to_back: got 1 expected 0");
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: addr %0h data %0h", bus.o_wr_addr, bus.o_wr_data);
        end else begin
          e = exp_q.pop_front();
          if ({bus.o_wr_addr, bus.o_wr_data} !== e) begin
            n_fail++;
            $display("FAIL wr_word: got addr %0h data %0h expected addr %0h data %0h",
                     bus.o_wr_addr, bus.o_wr_data, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
          end
        end
      end
      prev_wr_en = bus.o_wr_en;
    end
  end

  // Expected words for one session: row_ptr word at base, then one word
  // per started group of 64 col_idx entries at the following addresses
  task automatic push_session(input logic [ADDR_W-1:0] base, input int n_ci);
    logic [DATA_W-1:0] w;
    logic [ADDR_W-1:0] a;
    w = '0;
    for (int k = 0; k < RP_N; k++) w[k*RP_W +: RP_W] = rp_vals[k];
    exp_q.push_back({base, w});
    a = base;
    for (int n = 0; n < n_ci; n++) begin
      if (n % CI_N == 0) w = '0;
      w[(n % CI_N)*CI_W +: CI_W] = ci_vals[n];
      if ((n % CI_N == CI_N - 1) || (n == n_ci - 1)) begin
        a = a + 1'b1;
        exp_q.push_back({a, w});
      end
    end
  endtask

  task automatic fill_vals(input bit rp_mode, input bit ci_mode);
    for (int k = 0; k < RP_N; k++) rp_vals[k] = rp_mode ? RP_W'((k*37 + 11) % 256) : RP_W'(k);
    for (int n = 0; n < 256; n++) ci_vals[n] = ci_mode ? CI_W'((n*7 + 3) % 16) : CI_W'(n % 16);
  endtask

  // All drivers start and end at 1 time unit after a rising edge
  task automatic pulse_start(input logic [ADDR_W-1:0] base);
    bus.i_start = 1'b1;
    bus.i_base_addr = base;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
  endtask

  task automatic send_rp(input bit gaps);
    int k = 0;
    int guard = 0;
    bit fire;
    while (k < RP_N && guard < 1000) begin
      bus.i_rp_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.i_rp_data  = rp_vals[k];
      @(negedge clk);
      fire = bus.i_rp_valid && bus.o_rp_ready;
      @(posedge clk); #1;
      if (fire) k++;
      guard++;
    end
    bus.i_rp_valid = 1'b0;
    if (k < RP_N) check("rp_timeout", 64'(k), 64'(RP_N));
    else check("rp_write_next_cycle", 64'(bus.o_wr_en), 64'd1);
  endtask

  task automatic send_ci(input int n_ci, input bit gaps, input bit use_last, input bit start_mid);
    int n = 0;
    int guard = 0;
    bit fire;
    bit injected = 1'b0;
    while (n < n_ci && guard < 4000) begin
      bus.i_ci_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.i_ci_data  = ci_vals[n];
      bus.i_ci_last  = use_last && (n == n_ci - 1);
      if (start_mid && !injected && n == 20) begin
        bus.i_start = 1'b1;
        bus.i_base_addr = '0;
        injected = 1'b1;
      end else begin
        bus.i_start = 1'b0;
      end
      @(negedge clk);
      fire = bus.i_ci_valid && bus.o_ci_ready;
      @(posedge clk); #1;
      if (fire) n++;
      guard++;
    end
    bus.i_ci_valid = 1'b0;
    bus.i_ci_last  = 1'b0;
    bus.i_start    = 1'b0;
    if (n < n_ci) check("ci_timeout", 64'(n), 64'(n_ci));
    else if (use_last || n_ci == 256) check("ci_write_next_cycle", 64'(bus.o_wr_en), 64'd1);
  endtask

  task automatic run_session(input int idx, input sess_t s);
    int w0;
    int done_cnt = 0;
    fill_vals(s.rp_mode, s.ci_mode);
    push_session(s.base, s.n_ci);
    w0 = wr_count;
    pulse_start(s.base);
    check($sformatf("s%0d_start_state", idx), 64'(bus.o_state), 64'(RP_FILL));
    check($sformatf("s%0d_start_count", idx), 64'(bus.o_ci_count), 64'd0);
    send_rp(s.gaps);
    send_ci(s.n_ci, s.gaps, s.use_last, s.start_mid);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.o_done) done_cnt++;
    end
    @(posedge clk); #1;
    check($sformatf("s%0d_done_pulses", idx), 64'(done_cnt), 64'd1);
    check($sformatf("s%0d_end_state", idx), 64'(bus.o_state), 64'(IDLE));
    check($sformatf("s%0d_end_busy", idx), 64'(bus.o_busy), 64'd0);
    check($sformatf("s%0d_ci_count", idx), 64'(bus.o_ci_count), 64'(s.exp_count));
    check($sformatf("s%0d_writes", idx), 64'(wr_count - w0), 64'(s.exp_writes));
    check($sformatf("s%0d_queue_empty", idx), 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    sess_t tbl[6];
    int w0;
    tbl[0] = '{base:5'd3,  n_ci:128, rp_mode:0, ci_mode:0, gaps:0, start_mid:0, use_last:1, exp_writes:3, exp_count:8'd128};
    tbl[1] = '{base:5'd10, n_ci:5,   rp_mode:1, ci_mode:0, gaps:0, start_mid:0, use_last:1, exp_writes:2, exp_count:8'd5};
    tbl[2] = '{base:5'd31, n_ci:64,  rp_mode:1, ci_mode:1, gaps:0, start_mid:0, use_last:1, exp_writes:2, exp_count:8'd64};
    tbl[3] = '{base:5'd7,  n_ci:70,  rp_mode:1, ci_mode:1, gaps:0, start_mid:0, use_last:1, exp_writes:3, exp_count:8'd70};
    tbl[4] = '{base:5'd7,  n_ci:70,  rp_mode:1, ci_mode:1, gaps:1, start_mid:1, use_last:1, exp_writes:3, exp_count:8'd70};
    tbl[5] = '{base:5'd20, n_ci:256, rp_mode:1, ci_mode:1, gaps:0, start_mid:0, use_last:0, exp_writes:5, exp_count:8'd0};

    bus.i_start = 1'b0; bus.i_base_addr = '0;
    bus.i_rp_valid = 1'b0; bus.i_rp_data = '0;
    bus.i_ci_valid = 1'b0; bus.i_ci_data = '0; bus.i_ci_last = 1'b0;

    // Clock/reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_state", 64'(bus.o_state), 64'(IDLE));
    check("rst_busy", 64'(bus.o_busy), 64'd0);
    check("rst_done", 64'(bus.o_done), 64'd0);
    check("rst_wr_en", 64'(bus.o_wr_en), 64'd0);
    check("rst_wr_addr", 64'(bus.o_wr_addr), 64'd0);
    check("rst_wr_data_nonzero", 64'(bus.o_wr_data != '0), 64'd0);
    check("rst_ci_count", 64'(bus.o_ci_count), 64'd0);
    check("rst_rp_ready", 64'(bus.o_rp_ready), 64'd0);
    check("rst_ci_ready", 64'(bus.o_ci_ready), 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_session(i, tbl[i]);
      repeat (2) @(posedge clk);
      #1;
    end

    // Reset in CI_FILL after 30 entries: only the row_ptr word is written
    fill_vals(1'b0, 1'b0);
    push_session(5'd12, 0);
    pulse_start(5'd12);
    send_rp(1'b0);
    send_ci(30, 1'b0, 1'b0, 1'b0);
    check("mid_ci_count", 64'(bus.o_ci_count), 64'd30);
    check("mid_state", 64'(bus.o_state), 64'(CI_FILL));
    w0 = wr_count;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_state", 64'(bus.o_state), 64'(IDLE));
    check("mid_rst_count", 64'(bus.o_ci_count), 64'd0);
    check("mid_rst_wr_en", 64'(bus.o_wr_en), 64'd0);
    check("mid_rst_wr_addr", 64'(bus.o_wr_addr), 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("mid_rst_no_write", 64'(wr_count - w0), 64'd0);
    check("mid_rst_idle", 64'(bus.o_state), 64'(IDLE));
    check("mid_rst_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/csr_sram1_writer.md
CSR_SRAM1_WRITER -- requirements
Module: csr_sram1_writer

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_W, 256, SRAM1 word width.
- ADDR_W, 5, SRAM1 address width.
- RP_W, 8, row_ptr entry width.
- RP_N, 17, row_ptr entries per word.
- CI_W, 4, col_idx entry width.
- CI_N, 64, col_idx entries per word.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning); clock is i_clk, reset is i_rst, single clock domain, reset synchronous active-high:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_start  in  1  start pulse; latches i_base_addr.
- i_base_addr  in  5  address of the row_ptr word.
- i_rp_valid  in  1  row_ptr entry valid.
- i_rp_data  in  8  row_ptr entry.
- o_rp_ready  out  1  row_ptr accept.
- i_ci_valid  in  1  col_idx entry valid.
- i_ci_data  in  4  col_idx entry.
- i_ci_last  in  1  marks final col_idx entry.
- o_ci_ready  out  1  col_idx accept.
- o_wr_en  out  1  SRAM1 write strobe.
- o_wr_addr  out  5  SRAM1 write address.
- o_wr_data  out  256  SRAM1 write data.
- o_ci_count  out  8  col_idx entries accepted this session.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_state  out  3  current state encoding.

Function
REQ-003 Transfers SHALL occur only on cycles where valid && ready; o_rp_ready SHALL be high only in RP_FILL, and o_ci_ready only in CI_FILL.
REQ-004 States SHALL be IDLE=0, RP_FILL=1, RP_WRITE=2, CI_FILL=3, CI_WRITE=4, DONE=5.
REQ-005 IDLE with i_start SHALL go to RP_FILL, latching the address, clearing the buffer, and zeroing o_ci_count; i_start in any other state SHALL be ignored.
REQ-006 In RP_FILL, row_ptr entry k (0..16) SHALL be placed at buffer bits [8k+:8], with bits [255:136] zero; acceptance of entry 16 SHALL go to RP_WRITE.
REQ-007 In RP_WRITE, o_wr_en=1 for exactly one cycle with o_wr_addr=base; the address SHALL then increment, the buffer SHALL clear, and the state SHALL go to CI_FILL.
REQ-008 In CI_FILL, col_idx entry n SHALL be placed at bits [(n%64)*4+:4], and o_ci_count SHALL increment per transfer; transfer of the 64th entry in a word, or any transfer with i_ci_last=1, SHALL go to CI_WRITE.
REQ-009 In CI_WRITE, the device SHALL issue a one-cycle write of the buffer at the current address, with unused nibbles zero; it SHALL then increment the address and clear the buffer. It SHALL go to DONE if the last flag was captured, otherwise to CI_FILL.
REQ-010 The 256th col_idx transfer (o_ci_count wraps to 0) SHALL be treated as last regardless of i_ci_last.
REQ-011 The write SHALL be issued on the cycle immediately after the completing transfer; o_wr_en SHALL never be high in two consecutive cycles.
REQ-012 The address SHALL wrap 31->0 without error.
REQ-013 DONE SHALL assert o_done for one cycle and then return to IDLE; o_wr_data and o_wr_addr SHALL hold their last values while o_wr_en=0.

Reset
REQ-014 i_rst SHALL force IDLE and zero all outputs, buffer, address and counter on the next edge, including mid-session; no write for the aborted session SHALL follow reset.

Configuration
REQ-015 With CSR_SRAM1_WR_ABORT_EN defined, an input i_abort (1 bit) SHALL exist; i_abort=1 in any non-IDLE state SHALL go to IDLE next cycle with no pending write and no o_done. Without the macro, the port SHALL be absent and no abort path SHALL exist.

Structure
REQ-016 The shared package SHALL hold the state enum and the width/count constants (DATA_W, ADDR_W, RP_W, RP_N, CI_W, CI_N) shared with the SRAM1 reader.
REQ-017 One sub-module, csr_nibble_packer (lane-indexed write into a 256-bit register with clear), is natural; the FSM and address logic SHALL stay in the top module.

Verification
REQ-018 Start, base=3, row_ptr 0..16 -> a single write at addr 3 with data[135:0] = packed 0..16 and upper bits zero.
REQ-019 128 col_idx entries of value n%16, last on the 128th -> writes at addrs 4 and 5, o_ci_count=128, one o_done pulse.
REQ-020 5 col_idx entries, last on the 5th -> one write with nibbles 0..4 set and the rest zero, then DONE.
REQ-021 base=31 -> row_ptr written at 31, first col_idx word at 0.
REQ-022 i_rst during CI_FILL after 30 entries -> IDLE next cycle, o_wr_en never asserted, o_ci_count=0.
REQ-023 Valid held with gaps in valid, plus i_start mid-session -> identical packed data to the gap-free run, and i_start ignored.
